// File: rtl/mem_access_seq_pkg.sv
// Shared constants and helpers for the MEM-stage load/store sequencer.
// Access-size codes follow the RV32I load/store func3 field.
package mem_access_pkg;

  localparam logic [2:0] F3_B  = 3'd0;
  localparam logic [2:0] F3_H  = 3'd1;
  localparam logic [2:0] F3_W  = 3'd2;
  localparam logic [2:0] F3_BU = 3'd4;
  localparam logic [2:0] F3_HU = 3'd5;

  typedef enum logic {
    IDLE  = 1'b0,
    SPLIT = 1'b1
  } state_e;

  function automatic logic [2:0] bytes_of(input logic [2:0] f3);
    logic [2:0] n;
    case (f3)
      F3_H, F3_HU: n = 3'd2;
      F3_W:        n = 3'd4;
      default:     n = 3'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_seq_if.sv
// Data-memory port bundle between the sequencer (master)
// and the byte-addressed data memory (slave).
interface mem_access_seq_if #(
  parameter int ADDR_W = 12
);

  logic              dm_MemRead;
  logic              dm_MemWrite;
  logic [ADDR_W-1:0] dm_addr;
  logic [2:0]        dm_func3;
  logic [31:0]       dm_data_in;
  logic [31:0]       dm_data_out;

  modport master (
    output dm_MemRead,
    output dm_MemWrite,
    output dm_addr,
    output dm_func3,
    output dm_data_in,
    input  dm_data_out
  );

  modport slave (
    input  dm_MemRead,
    input  dm_MemWrite,
    input  dm_addr,
    input  dm_func3,
    input  dm_data_in,
    output dm_data_out
  );

endinterface

// File: rtl/mem_access_seq_load_extend.sv
// Load result extension by func3: sign/zero extend bytes and
// halfwords, words pass unchanged.
module load_extend
  import mem_access_pkg::*;
(
  input  logic [2:0]  func3,
  input  logic [31:0] raw,
  output logic [31:0] result
);

  always_comb begin
    result = raw;
    unique case (1'b1)
      (func3 == F3_B):  result = {{24{raw[7]}}, raw[7:0]};
      (func3 == F3_BU): result = {24'h0, raw[7:0]};
      (func3 == F3_H):  result = {{16{raw[15]}}, raw[15:0]};
      (func3 == F3_HU): result = {16'h0, raw[15:0]};
      default:          result = raw;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// MEM-stage load/store sequencer: aligned accesses pass through,
// misaligned ones are split into byte accesses under stall.
module mem_access_seq
  import mem_access_pkg::*;
#(
  parameter int ADDR_W           = 12,
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [2:0]        func3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       store_data,
  mem_access_seq_if.master  dm,
  output logic [31:0]       load_data,
  output logic              stall,
  output logic              err
);

  state_e            state_q, state_d;
  logic [1:0]        idx_q, idx_d;
  logic [23:0]       asm_q, asm_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [2:0]        f3_q, f3_d;
  logic [31:0]       sd_q, sd_d;
  logic              wr_q, wr_d;

  logic        legal_ld, legal_st, legal;
  logic        aligned, last;
  logic [2:0]  n_in, n_q;
  logic [7:0]  cur;
  logic [31:0] sd_sh;
  logic [2:0]  ext_f3;
  logic [31:0] ext_raw, ext_out;

  assign legal_ld = MemRead & ~MemWrite &
    (func3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
  assign legal_st = MemWrite & ~MemRead &
    (func3 inside {F3_B, F3_H, F3_W});
  assign legal = legal_ld | legal_st;

  assign n_in    = bytes_of(func3);
  assign n_q     = bytes_of(f3_q);
  assign aligned = (n_in == 3'd1) |
                   ((n_in == 3'd2) & ~addr[0]) |
                   (addr[1:0] == 2'b00);
  assign last    = ({1'b0, idx_q} == (n_q - 3'd1));
  assign cur     = dm.dm_data_out[7:0];
  assign sd_sh   = sd_q >> {idx_q, 3'b000};

  load_extend u_ext (
    .func3  (ext_f3),
    .raw    (ext_raw),
    .result (ext_out)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    asm_d   = asm_q;
    addr_d  = addr_q;
    f3_d    = f3_q;
    sd_d    = sd_q;
    wr_d    = wr_q;

    dm.dm_MemRead  = 1'b0;
    dm.dm_MemWrite = 1'b0;
    dm.dm_addr     = '0;
    dm.dm_func3    = 3'd0;
    dm.dm_data_in  = 32'h0;
    load_data      = 32'h0;
    stall          = 1'b0;
    err            = 1'b0;
    ext_f3         = func3;
    ext_raw        = dm.dm_data_out;

    unique case (state_q)
      IDLE: begin
        if (legal && aligned) begin
          dm.dm_MemRead  = MemRead;
          dm.dm_MemWrite = MemWrite;
          dm.dm_addr     = addr;
          dm.dm_func3    = func3;
          dm.dm_data_in  = store_data;
          if (MemRead) load_data = ext_out;
        end else if (legal && ALLOW_MISALIGNED) begin
          dm.dm_MemRead  = MemRead;
          dm.dm_MemWrite = MemWrite;
          dm.dm_addr     = addr;
          dm.dm_func3    = MemWrite ? F3_B : F3_BU;
          dm.dm_data_in  = {24'h0, store_data[7:0]};
          stall          = 1'b1;
          asm_d          = {16'h0, cur};
          idx_d          = 2'd1;
          addr_d         = addr;
          f3_d           = func3;
          sd_d           = store_data;
          wr_d           = MemWrite;
          state_d        = SPLIT;
        end else if (MemRead || MemWrite) begin
          err = 1'b1;
        end
      end
      SPLIT: begin
        dm.dm_MemRead  = ~wr_q;
        dm.dm_MemWrite = wr_q;
        dm.dm_addr     = addr_q + ADDR_W'(idx_q);
        dm.dm_func3    = wr_q ? F3_B : F3_BU;
        dm.dm_data_in  = {24'h0, sd_sh[7:0]};
        ext_f3         = f3_q;
        // halfword uses only the first assembled byte
        ext_raw = (n_q == 3'd2) ? {16'h0, cur, asm_q[7:0]}
                                : {cur, asm_q};
        if (last) begin
          if (!wr_q) load_data = ext_out;
          idx_d   = 2'd0;
          state_d = IDLE;
        end else begin
          stall = 1'b1;
          asm_d = asm_q | (24'(cur) << {idx_q, 3'b000});
          idx_d = idx_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (!rst_n) begin
      dm.dm_MemRead  = 1'b0;
      dm.dm_MemWrite = 1'b0;
      dm.dm_addr     = '0;
      dm.dm_func3    = 3'd0;
      dm.dm_data_in  = 32'h0;
      load_data      = 32'h0;
      stall          = 1'b0;
      err            = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= 2'd0;
      asm_q   <= 24'h0;
      addr_q  <= '0;
      f3_q    <= 3'd0;
      sd_q    <= 32'h0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      addr_q  <= addr_d;
      f3_q    <= f3_d;
      sd_q    <= sd_d;
      wr_q    <= wr_d;
    end
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: byte memory model plus an
// access-level reference of expected bus cycles and results.
module tb_mem_access_seq;
  import mem_access_pkg::*;

  localparam int AW = 12;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          rd, wr;
  logic [2:0]    f3;
  logic [AW-1:0] a;
  logic [31:0]   sd;
  logic [31:0]   ld, ld0;
  logic          st, st0, er, er0;

  mem_access_seq_if #(.ADDR_W(AW)) bus ();
  mem_access_seq_if #(.ADDR_W(AW)) bus0 ();

  mem_access_seq #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .MemRead(rd), .MemWrite(wr),
    .func3(f3), .addr(a), .store_data(sd), .dm(bus.master),
    .load_data(ld), .stall(st), .err(er)
  );

  mem_access_seq #(.ADDR_W(AW), .ALLOW_MISALIGNED(1'b0)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd), .MemWrite(wr),
    .func3(f3), .addr(a), .store_data(sd), .dm(bus0.master),
    .load_data(ld0), .stall(st0), .err(er0)
  );

  assign bus0.dm_data_out = 32'h0;

  logic [7:0] mem     [4096];
  logic [7:0] ref_mem [4096];

  logic [AW-1:0] p0, p1, p2, p3;
  logic [7:0]    b0, b1, b2, b3;

  always_comb begin
    p0 = bus.dm_addr;
    p1 = p0 + 12'd1;
    p2 = p0 + 12'd2;
    p3 = p0 + 12'd3;
    b0 = mem[p0];
    b1 = mem[p1];
    b2 = mem[p2];
    b3 = mem[p3];
    case (bus.dm_func3)
      3'd0:    bus.dm_data_out = {{24{b0[7]}}, b0};
      3'd4:    bus.dm_data_out = {24'h0, b0};
      3'd1:    bus.dm_data_out = {{16{b1[7]}}, b1, b0};
      3'd5:    bus.dm_data_out = {16'h0, b1, b0};
      3'd2:    bus.dm_data_out = {b3, b2, b1, b0};
      default: bus.dm_data_out = 32'h0;
    endcase
  end

  always @(posedge clk) begin
    if (bus.dm_MemWrite) begin
      mem[p0] = bus.dm_data_in[7:0];
      if (bus.dm_func3 != 3'd0) mem[p1] = bus.dm_data_in[15:8];
      if (bus.dm_func3 == 3'd2) begin
        mem[p2] = bus.dm_data_in[23:16];
        mem[p3] = bus.dm_data_in[31:24];
      end
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)",
               tag, got, exp, $time);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    if (f == 3'd1 || f == 3'd5) return 2;
    if (f == 3'd2) return 4;
    return 1;
  endfunction

  // value of n little-endian bytes, then sign/zero extension
  function automatic logic [31:0] ref_load(input logic [2:0] f,
                                           input int addr_i);
    longint unsigned v, lim;
    int n;
    n = nbytes(f);
    v = 0;
    for (int i = 0; i < n; i++)
      v += longint'(ref_mem[(addr_i + i) % 4096]) << (8 * i);
    lim = 64'd1 << (8 * n);
    if ((f == 3'd0 || f == 3'd1) && v >= lim / 2)
      v = v + (64'h1_0000_0000 - lim);
    return v[31:0];
  endfunction

  task automatic poke(input int addr_i, input logic [7:0] v);
    mem[addr_i]     = v;
    ref_mem[addr_i] = v;
  endtask

  task automatic run_req(input logic rd_i, input logic wr_i,
                         input logic [2:0] f_i, input int a_i,
                         input logic [31:0] sd_i);
    int  n, ai;
    bit  legal, aligned;
    logic [31:0] exp_ld;
    @(negedge clk);
    rd = rd_i; wr = wr_i; f3 = f_i; a = AW'(a_i); sd = sd_i;
    ai = a_i % 4096;
    n  = nbytes(f_i);
    legal = (rd_i ^ wr_i) &&
      (rd_i ? (f_i inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})
            : (f_i inside {3'd0, 3'd1, 3'd2}));
    aligned = (ai % n) == 0;
    exp_ld  = ref_load(f_i, ai);
    #1;
    if (!legal) begin
      chk("illegal_err", {31'h0, er}, {31'h0, rd_i | wr_i});
      chk("illegal_strobe", {30'h0, bus.dm_MemRead, bus.dm_MemWrite}, 0);
      chk("illegal_stall", {31'h0, st}, 0);
      chk("illegal_err0", {31'h0, er0}, {31'h0, rd_i | wr_i});
      if (!(rd_i | wr_i)) chk("idle_ld", ld, 0);
    end else if (aligned) begin
      chk("al_strobe", {30'h0, bus.dm_MemRead, bus.dm_MemWrite},
          {30'h0, rd_i, wr_i});
      chk("al_addr", 32'(bus.dm_addr), ai);
      chk("al_func3", 32'(bus.dm_func3), 32'(f_i));
      chk("al_stall_err", {30'h0, st, er}, 0);
      chk("al_err0", {31'h0, er0}, 0);
      if (rd_i) chk("al_load", ld, exp_ld);
      if (wr_i) begin
        chk("al_wdata", bus.dm_data_in, sd_i);
        for (int i = 0; i < n; i++)
          ref_mem[(ai + i) % 4096] = 8'(sd_i >> (8 * i));
      end
    end else begin
      chk("mis_err0", {31'h0, er0}, 1);
      chk("mis_strobe0", {30'h0, bus0.dm_MemRead, bus0.dm_MemWrite}, 0);
      for (int i = 0; i < n; i++) begin
        if (i > 0) begin
          @(negedge clk);
          #1;
        end
        chk("mis_addr", 32'(bus.dm_addr), (ai + i) % 4096);
        chk("mis_strobe", {30'h0, bus.dm_MemRead, bus.dm_MemWrite},
            {30'h0, rd_i, wr_i});
        chk("mis_func3", 32'(bus.dm_func3), wr_i ? 0 : 4);
        chk("mis_stall", {31'h0, st}, (i < n - 1) ? 1 : 0);
        chk("mis_err", {31'h0, er}, 0);
        if (wr_i) begin
          chk("mis_wbyte", 32'(bus.dm_data_in[7:0]),
              32'(8'(sd_i >> (8 * i))));
          ref_mem[(ai + i) % 4096] = 8'(sd_i >> (8 * i));
        end
        if (rd_i && i == n - 1) chk("mis_load", ld, exp_ld);
      end
    end
  endtask

  initial begin
    int bad;
    logic [2:0] ftab [8];
    ftab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 4096; i++) poke(i, 8'($urandom));
    rd = 1'b1; wr = 1'b0; f3 = 3'd2; a = 12'h010; sd = 32'h0;

    // reset: outputs forced low even with a request present
    repeat (2) @(negedge clk);
    #1;
    chk("rst_strobe", {30'h0, bus.dm_MemRead, bus.dm_MemWrite}, 0);
    chk("rst_ld_stall_err", {ld[31:2], st, er}, 0);
    @(negedge clk);
    rst_n = 1'b1; rd = 1'b0;
    #1;
    chk("post_rst_idle", {ld[31:2], st, er}, 0);

    poke(16'h10, 8'hEF); poke(16'h11, 8'hBE);
    poke(16'h12, 8'hAD); poke(16'h13, 8'hDE);
    run_req(1, 0, F3_W, 12'h010, 0);
    chk("lw_literal", ld, 32'hDEADBEEF);

    run_req(0, 1, F3_W, 12'h005, 32'h11223344);
    @(negedge clk);
    rd = 0; wr = 0;
    chk("sw_mem", {mem[8], mem[7], mem[6], mem[5]}, 32'h11223344);

    poke(7, 8'h80); poke(8, 8'hFF);
    run_req(1, 0, F3_H, 7, 0);
    chk("lh_literal", ld, 32'hFFFFFF80);
    run_req(1, 0, F3_HU, 7, 0);
    chk("lhu_literal", ld, 32'h0000FF80);

    run_req(1, 0, F3_W, 12'hFFE, 0);
    run_req(0, 1, F3_BU, 12'h020, 32'h5A5A5A5A);
    run_req(1, 1, F3_W, 12'h020, 32'h0);
    run_req(1, 0, F3_W, 12'h021, 0);

    for (int k = 0; k < 300; k++) begin
      int sel, fi, ai;
      logic r, w;
      sel = $urandom_range(0, 9);
      r = (sel < 5) || (sel == 9 && $urandom_range(0, 1) == 1);
      w = (sel >= 5 && sel < 9) || (sel == 9 && r);
      fi = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 4)
                                      : $urandom_range(5, 7);
      ai = ($urandom_range(0, 3) == 0) ? 12'hFFC + $urandom_range(0, 3)
                                       : $urandom_range(0, 4095);
      run_req(r, w, ftab[fi], ai, $urandom);
    end
    @(negedge clk);
    rd = 0; wr = 0;

    // reset during the second byte of a misaligned sw
    poke(1, 8'h00); poke(2, 8'hA5);
    @(negedge clk);
    rd = 0; wr = 1; f3 = F3_W; a = 12'h001; sd = 32'h11223344;
    #1;
    chk("abort_b0_stall", {31'h0, st}, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_strobe", {30'h0, bus.dm_MemRead, bus.dm_MemWrite}, 0);
    chk("abort_outs", {ld[31:2], st, er}, 0);
    chk("abort_addr", 32'(bus.dm_addr), 0);
    @(negedge clk);
    rst_n = 1'b1; rd = 1; wr = 0; f3 = F3_BU; a = 12'h040;
    #1;
    chk("abort_idle_addr", 32'(bus.dm_addr), 32'h040);
    chk("abort_idle_stall", {31'h0, st}, 0);
    chk("abort_idle_ld", ld, {24'h0, ref_mem[12'h040]});
    chk("abort_mem1", 32'(mem[1]), 32'h44);
    chk("abort_mem2", 32'(mem[2]), 32'hA5);
    ref_mem[1] = 8'h44;
    @(negedge clk);
    rd = 0;

    bad = 0;
    for (int i = 0; i < 4096; i++)
      if (mem[i] !== ref_mem[i]) bad++;
    chk("mem_image", bad, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_access_seq.md
Name: mem_access_seq

Overview:
- MEM-stage load/store sequencer between the EX/MEM pipeline register and the byte-addressed data memory.
- Aligned accesses pass straight through in one cycle.
- Misaligned halfword/word accesses are split into sequential byte accesses, with the pipeline stalled until the last byte.
- Loads are reassembled and sign/zero-extended by func3 before write-back.

Parameters:
- ADDR_W, 12, byte-address width; matches the data memory.
- ALLOW_MISALIGNED, 1, 1 = split misaligned accesses; 0 = flag err and perform no access.

Ports:
- clk  in  1  clock; all state updates on posedge
- rst_n  in  1  synchronous reset, active-low
- MemRead  in  1  load request from EX/MEM
- MemWrite  in  1  store request from EX/MEM
- func3  in  3  access type: 0 lb/sb, 1 lh/sh, 2 lw/sw, 4 lbu, 5 lhu
- addr  in  ADDR_W  byte address from ALU
- store_data  in  32  rs2 value for stores
- dm_MemRead  out  1  read strobe to data memory
- dm_MemWrite  out  1  write strobe to data memory
- dm_addr  out  ADDR_W  address to data memory
- dm_func3  out  3  access size to data memory
- dm_data_in  out  32  write data to data memory
- dm_data_out  in  32  asynchronous read data from data memory
- load_data  out  32  extended load result to MEM/WB
- stall  out  1  hold PC, IF/ID, ID/EX and EX/MEM
- err  out  1  illegal access this cycle

Behaviour:
- Reset (rst_n low at posedge): state=IDLE, idx=0, assembly register=0.
  - While rst_n is low, all outputs are forced to 0 combinationally.
- Legal request: exactly one of MemRead/MemWrite is set and func3 is in {0,1,2,4,5}.
  - Loads accept 0,1,2,4,5; stores accept 0,1,2.
  - Anything else with a strobe set: err=1, no dm strobe, stall=0.
  - Both strobes low: idle; outputs 0 except load_data=0.
- Aligned test:
  - byte: always aligned
  - half: addr[0]==0
  - word: addr[1:0]==00
- IDLE, aligned, legal:
  - Pure pass-through, zero added latency, combinational.
  - dm_* = inputs, with dm_func3=func3 (the memory extends).
  - load_data = dm_data_out; stall=0.
- IDLE, misaligned, legal, ALLOW_MISALIGNED=1:
  - N = 2 (half) or 4 (word).
  - Issue byte 0 this cycle: dm_addr=addr; dm_func3=4 for loads, 0 for stores; dm_data_in[7:0]=store_data[7:0].
  - stall=1.
  - At posedge: capture dm_data_out[7:0] into asm[7:0]; idx<=1; latch addr, func3, store_data and the read/write flag; go to SPLIT.
- IDLE, misaligned, ALLOW_MISALIGNED=0: err=1, no access.
- SPLIT, for idx in 1..N-1:
  - dm_addr = latched addr + idx, modulo 2^ADDR_W (0xFFF+1 wraps to 0x000).
  - Byte access; store byte = store_data[8*idx+7 : 8*idx].
  - For idx<N-1: stall=1; capture byte into asm; idx++.
  - For idx==N-1: stall=0.
    - load_data = extend({current byte, asm}) per latched func3: 1 sign-extends bit 15, 5 zero-extends, 2 takes all 32 bits.
    - At posedge return to IDLE with idx=0.
- Request inputs are ignored in SPLIT; the pipeline holds them stable via stall.
- Latency:
  - aligned: 0 stall cycles
  - misaligned half: 1 stall cycle
  - misaligned word: 3 stall cycles
- Reset mid-SPLIT aborts at that edge.
  - Bytes already written stay in memory; no further strobes are issued.
- Stores never assert dm_MemRead. Loads never assert dm_MemWrite.

Decomposition:
- Package mem_access_pkg holds:
  - func3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5
  - state encoding IDLE/SPLIT
  - function bytes_of(func3) returning 1/2/4
- Sub-module load_extend: combinational, (func3, raw[31:0]) -> extended 32-bit result. Reused on the pass-through path for verification cross-checks.

Test Plan:
- Aligned lw at addr 0x010, memory holds 0xDEADBEEF -> load_data=0xDEADBEEF in the same cycle; stall never asserted.
- Misaligned sw 0x11223344 at 0x005 -> 4 cycles; dm_addr 0x005..0x008 with bytes 44,33,22,11; stall=1,1,1,0.
- Misaligned lh at 0x007, mem[7]=0x80, mem[8]=0xFF -> after 1 stall cycle load_data=0xFFFFFF80. Repeat as lhu -> 0x0000FF80.
- Misaligned lw at 0xFFE -> byte accesses at 0xFFE, 0xFFF, 0x000, 0x001; result assembled little-endian.
- rst_n low during the second byte of a misaligned sw at 0x001 -> only mem[1] is written; outputs 0; state IDLE next cycle.
- Illegal requests raise err=1 with no dm strobes:
  - store with func3=4
  - MemRead and MemWrite both set
  - misaligned lw with ALLOW_MISALIGNED=0
